alu_muldiv_controller: RTL and testbench

//  Parametrised successor to the RV32I ALU controller for the execute stage.
//  - Decodes opcode/funct3/funct7/alu_op into the 4-bit ALU control, as before.
//  - Adds an iterative RV32M multiply/divide unit with its own FSM.
//  - Stalls the pipeline while a MUL/DIV op runs and returns its result with a one-cycle valid pulse.

---
 rtl/alu_muldiv_controller.sv | 167 ++++++++++++++++
 tb/tb_alu_muldiv_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_controller.sv
// Execute-stage ALU controller with an iterative RV32M multiply/divide unit.
// Decodes the 4-bit ALU control and sequences shift-add MUL and restoring DIV ops.
module alu_muldiv_controller #(
    parameter int unsigned REG_DATA_WIDTH = 32,
    parameter bit          ENABLE_M       = 1'b1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic [6:0]                funct7,
    input  logic [1:0]                alu_op,
    input  logic                      valid_in,
    input  logic [REG_DATA_WIDTH-1:0] rs1_data,
    input  logic [REG_DATA_WIDTH-1:0] rs2_data,
    output logic [3:0]                alu_ctrl,
    output logic                      stall,
    output logic                      md_valid,
    output logic [REG_DATA_WIDTH-1:0] md_result
);
    localparam int unsigned W  = REG_DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    localparam logic [3:0] AluAnd = 4'b0000, AluOr = 4'b0001, AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110, AluSlt = 4'b0111, AluSltu = 4'b1000;
    localparam logic [3:0] AluXor = 4'b1001, AluSll = 4'b1010, AluSrl = 4'b1011;
    localparam logic [3:0] AluSra = 4'b1100, AluPassB = 4'b1101, AluMulDiv = 4'b1111;
    localparam logic [6:0] OpR = 7'b0110011, OpI = 7'b0010011;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e          state_q;
    logic [2:0]      f3_q;
    logic            neg_a_q, neg_b_q;
    logic [CW-1:0]   cnt_q;
    logic [2*W-1:0]  prod_q, mcand_q;
    logic [W-1:0]    mplier_q, quot_q, rem_q, dvsr_q, result_q;

    always_comb begin
        alu_ctrl = AluAdd;
        unique case (alu_op)
            2'b00: alu_ctrl = AluAdd;
            2'b01: alu_ctrl = AluSub;
            2'b11: alu_ctrl = AluPassB;
            2'b10: begin
                if (ENABLE_M && opcode == OpR && funct7 == 7'b0000001) begin
                    alu_ctrl = AluMulDiv;
                end else if (opcode == OpR || opcode == OpI) begin
                    case (funct3)
                        3'b000:  alu_ctrl = (opcode == OpR && funct7[5]) ? AluSub : AluAdd;
                        3'b001:  alu_ctrl = AluSll;
                        3'b010:  alu_ctrl = AluSlt;
                        3'b011:  alu_ctrl = AluSltu;
                        3'b100:  alu_ctrl = AluXor;
                        3'b101:  alu_ctrl = funct7[5] ? AluSra : AluSrl;
                        3'b110:  alu_ctrl = AluOr;
                        default: alu_ctrl = AluAnd;
                    endcase
                end
            end
            default: alu_ctrl = AluAdd;
        endcase
    end

    logic         start, a_signed, b_signed, neg_a, neg_b;
    logic [W-1:0] mag_a, mag_b;

    always_comb begin
        start    = (alu_ctrl == AluMulDiv) && valid_in && (state_q == StIdle);
        // MULH, MULHSU, DIV, REM treat rs1 as signed; only MULH, DIV, REM treat rs2 as signed.
        a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                   (funct3 == 3'b110);
        b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a    = a_signed && rs1_data[W-1];
        neg_b    = b_signed && rs2_data[W-1];
        mag_a    = neg_a ? -rs1_data : rs1_data;
        mag_b    = neg_b ? -rs2_data : rs2_data;
    end

    logic [W:0]     rem_shift, diff;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s, rem_s, final_result;
    logic           div_zero;

    always_comb begin
        rem_shift = {rem_q, quot_q[W-1]};
        diff      = rem_shift - {1'b0, dvsr_q};
        div_zero  = (dvsr_q == '0);
        prod_s    = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
        quot_s    = div_zero ? '1 : ((neg_a_q ^ neg_b_q) ? -quot_q : quot_q);
        // On divide by zero the quotient register still holds |rs1|.
        if (div_zero) rem_s = neg_a_q ? -quot_q : quot_q;
        else          rem_s = neg_a_q ? -rem_q : rem_q;
        case (f3_q)
            3'b000:                 final_result = prod_s[W-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_s[2*W-1:W];
            3'b100, 3'b101:         final_result = quot_s;
            default:                final_result = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= StIdle;
            f3_q     <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                StIdle: if (start) begin
                    f3_q     <= funct3;
                    neg_a_q  <= neg_a;
                    neg_b_q  <= neg_b;
                    cnt_q    <= '0;
                    prod_q   <= '0;
                    mcand_q  <= {{W{1'b0}}, mag_a};
                    mplier_q <= mag_b;
                    quot_q   <= mag_a;
                    rem_q    <= '0;
                    dvsr_q   <= mag_b;
                    state_q  <= funct3[2] ? StDiv : StMul;
                end
                StMul: begin
                    if (mplier_q[0]) prod_q <= prod_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) state_q <= StDone;
                end
                StDiv: begin
                    if (div_zero) begin
                        state_q <= StDone;
                    end else begin
                        if (!diff[W]) begin
                            rem_q  <= diff[W-1:0];
                            quot_q <= {quot_q[W-2:0], 1'b1};
                        end else begin
                            rem_q  <= rem_shift[W-1:0];
                            quot_q <= {quot_q[W-2:0], 1'b0};
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CntLast) state_q <= StDone;
                    end
                end
                StDone: begin
                    result_q <= final_result;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign stall     = start || (state_q == StMul) || (state_q == StDiv);
    assign md_valid  = (state_q == StDone);
    assign md_result = md_valid ? final_result : result_q;

endmodule

// File: tb/tb_alu_muldiv_controller.sv
// Randomised self-checking bench for alu_muldiv_controller against an arithmetic model.
module tb_alu_muldiv_controller;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [6:0]   opcode = '0;
    logic [2:0]   funct3 = '0;
    logic [6:0]   funct7 = '0;
    logic [1:0]   alu_op = '0;
    logic         valid_in = 1'b0;
    logic [W-1:0] rs1_data = '0;
    logic [W-1:0] rs2_data = '0;
    logic [3:0]   alu_ctrl;
    logic         stall;
    logic         md_valid;
    logic [W-1:0] md_result;

    int n_checks = 0;
    int n_fail   = 0;

    alu_muldiv_controller #(.REG_DATA_WIDTH(W), .ENABLE_M(1'b1)) dut (
        .clk(clk), .nreset(nreset), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_op(alu_op), .valid_in(valid_in), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_ctrl(alu_ctrl), .stall(stall), .md_valid(md_valid), .md_result(md_result)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_alu(logic [6:0] opc, logic [2:0] f3, logic [6:0] f7,
                                           logic [1:0] aop);
        if (aop == 2'b00) return 4'b0010;
        if (aop == 2'b01) return 4'b0110;
        if (aop == 2'b11) return 4'b1101;
        if (opc == 7'h33 && f7 == 7'h01) return 4'b1111;
        if (opc != 7'h33 && opc != 7'h13) return 4'b0010;
        case (f3)
            3'd0: return (opc == 7'h33 && f7[5]) ? 4'b0110 : 4'b0010;
            3'd1: return 4'b1010;
            3'd2: return 4'b0111;
            3'd3: return 4'b1000;
            3'd4: return 4'b1001;
            3'd5: return f7[5] ? 4'b1100 : 4'b1011;
            3'd6: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        int          ia = a;
        int          ib = b;
        logic [63:0] p;
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issues one M op in an IDLE cycle; returns the cycle count to md_valid (-1 on timeout),
    // cycles with stall high before it, and the outputs one cycle after the pulse.
    task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stall_cyc,
                          output logic start_stall, output logic done_stall,
                          output logic after_valid, output logic [31:0] after_res);
        @(negedge clk);
        opcode = 7'h33; funct7 = 7'h01; funct3 = f3; alu_op = 2'b10;
        rs1_data = a; rs2_data = b; valid_in = 1'b1;
        #1 start_stall = stall;
        @(posedge clk);
        #1 valid_in = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
        #1;
        lat = -1; stall_cyc = 0; res = 'x; done_stall = 1'bx;
        after_valid = 1'bx; after_res = 'x;
        for (int k = 1; k <= 80; k++) begin
            if (md_valid === 1'b1) begin
                lat = k; res = md_result; done_stall = stall;
                break;
            end
            if (stall === 1'b1) stall_cyc++;
            @(posedge clk);
            #2;
        end
        @(posedge clk);
        #2 after_valid = md_valid; after_res = md_result;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_fail++;
            $display("FAIL reset_stall: got %b want 0", stall); end
        n_checks++; if (md_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_md_valid: got %b want 0", md_valid); end
        n_checks++; if (md_result !== '0) begin n_fail++;
            $display("FAIL reset_md_result: got %h want 0", md_result); end
        @(negedge clk) nreset = 1'b1;
    endtask

    task automatic test_decode();
        logic [3:0] exp;
        valid_in = 1'b0;
        opcode = 7'h33; funct3 = 3'b000; funct7 = 7'h20; alu_op = 2'b10;
        #1 n_checks++; if (alu_ctrl !== 4'b0110) begin n_fail++;
            $display("FAIL decode_r_sub: got %b want 0110", alu_ctrl); end
        opcode = 7'h13;
        #1 n_checks++; if (alu_ctrl !== 4'b0010) begin n_fail++;
            $display("FAIL decode_i_add: got %b want 0010", alu_ctrl); end
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 2))
                0: opcode = 7'h33;
                1: opcode = 7'h13;
                default: opcode = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0: funct7 = 7'h00;
                1: funct7 = 7'h20;
                2: funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            funct3 = 3'($urandom);
            alu_op = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10;
            exp = ref_alu(opcode, funct3, funct7, alu_op);
            #1 n_checks++; if (alu_ctrl !== exp) begin n_fail++;
                $display("FAIL decode_rand op=%h f3=%h f7=%h aop=%b: got %b want %b",
                         opcode, funct3, funct7, alu_op, alu_ctrl, exp); end
        end
    endtask

    task automatic test_mul_directed();
        logic [31:0] res, ares; int lat, sc; logic ss, ds, av;
        run_md(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'hFFFF_FFEB) begin n_fail++;
            $display("FAIL mul_7x-3: got %h want ffffffeb", res); end
        n_checks++; if (lat !== W + 1) begin n_fail++;
            $display("FAIL mul_latency: got %0d want %0d", lat, W + 1); end
        n_checks++; if (ss !== 1'b1 || sc !== W || ds !== 1'b0) begin n_fail++;
            $display("FAIL mul_stall: start=%b cycles=%0d done=%b want 1 %0d 0", ss, sc, ds, W);
        end
        n_checks++; if (av !== 1'b0 || ares !== 32'hFFFF_FFEB) begin n_fail++;
            $display("FAIL mul_hold: valid=%b res=%h want 0 ffffffeb", av, ares); end
        run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'hFFFF_FFFE) begin n_fail++;
            $display("FAIL mulhu_ones: got %h want fffffffe", res); end
        run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'h0) begin n_fail++;
            $display("FAIL mulh_ones: got %h want 00000000", res); end
    endtask

    task automatic test_div_directed();
        logic [31:0] res, ares; int lat, sc; logic ss, ds, av;
        run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'h8000_0000 || lat !== W + 1) begin n_fail++;
            $display("FAIL div_overflow: got %h lat %0d want 80000000 lat %0d", res, lat, W + 1);
        end
        run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'h0) begin n_fail++;
            $display("FAIL rem_overflow: got %h want 0", res); end
        run_md(3'd4, 32'd5, 32'd0, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'hFFFF_FFFF || lat !== 2) begin n_fail++;
            $display("FAIL div_by_zero: got %h lat %0d want ffffffff lat 2", res, lat); end
        n_checks++; if (ss !== 1'b1 || sc !== 1 || ds !== 1'b0) begin n_fail++;
            $display("FAIL div0_stall: start=%b cycles=%0d done=%b want 1 1 0", ss, sc, ds); end
        run_md(3'd6, 32'd5, 32'd0, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'd5) begin n_fail++;
            $display("FAIL rem_by_zero: got %h want 5", res); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res, ares; int lat, sc; logic ss, ds, av;
        run_md(3'd5, 32'd100, 32'd7, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'd14) begin n_fail++;
            $display("FAIL b2b_divu: got %0d want 14", res); end
        // run_md returns inside the IDLE cycle right after md_valid, so this starts immediately.
        run_md(3'd7, 32'd100, 32'd7, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'd2 || lat !== W + 1 || ss !== 1'b1) begin n_fail++;
            $display("FAIL b2b_remu: got %0d lat %0d start_stall %b want 2 lat %0d 1",
                     res, lat, ss, W + 1); end
    endtask

    task automatic test_random_md();
        logic [31:0] a, b, res, ares, exp; logic [2:0] f3; int lat, sc, exp_lat; logic ss, ds, av;
        for (int i = 0; i < 48; i++) begin
            f3 = 3'($urandom); a = rand_operand(); b = rand_operand();
            exp = ref_md(f3, a, b);
            exp_lat = (f3[2] && b == 0) ? 2 : W + 1;
            run_md(f3, a, b, res, lat, sc, ss, ds, av, ares);
            n_checks++; if (res !== exp) begin n_fail++;
                $display("FAIL rand_result f3=%0d a=%h b=%h: got %h want %h", f3, a, b, res, exp);
            end
            n_checks++; if (lat !== exp_lat) begin n_fail++;
                $display("FAIL rand_latency f3=%0d b=%h: got %0d want %0d", f3, b, lat, exp_lat);
            end
        end
    endtask

    task automatic test_abort();
        logic [31:0] res, ares; int lat, sc, pulses; logic ss, ds, av;
        @(negedge clk);
        opcode = 7'h33; funct7 = 7'h01; funct3 = 3'd0; alu_op = 2'b10;
        rs1_data = 32'd1234; rs2_data = 32'd5678; valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (9) @(posedge clk);
        #1 nreset = 1'b0;
        #1 n_checks++; if (stall !== 1'b0 || md_valid !== 1'b0) begin n_fail++;
            $display("FAIL abort_outputs: stall=%b md_valid=%b want 0 0", stall, md_valid); end
        repeat (2) @(posedge clk);
        #1 n_checks++; if (md_result !== '0) begin n_fail++;
            $display("FAIL abort_result: got %h want 0", md_result); end
        @(negedge clk) nreset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1 if (md_valid === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++;
            $display("FAIL abort_no_pulse: got %0d pulses want 0", pulses); end
        run_md(3'd0, 32'd3, 32'd4, res, lat, sc, ss, ds, av, ares);
        n_checks++; if (res !== 32'd12 || lat !== W + 1) begin n_fail++;
            $display("FAIL abort_then_mul: got %0d lat %0d want 12 lat %0d", res, lat, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul_directed();
        test_div_directed();
        test_back_to_back();
        test_random_md();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
